// File: rtl/csr_regfile.sv
// csr_regfile: control/status register file with exception entry/return
// bookkeeping, interrupt pending logic and a down-counting timer.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   csr_num             CSR address used for both read and write
//   csr_rvalue          combinational read data for csr_num (0 if undecoded)
//   csr_we/wmask/wvalue masked CSR write, applied at the next clk edge
//   hw_int_in           8 level hardware interrupt lines, sampled every cycle
//   ipi_int_in          level inter-core interrupt, sampled every cycle
//   wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr
//                       exception commit from WB and its cause/address info
//   ertn_flush          exception-return commit from WB
//   ex_entry            exception entry address {EENTRY.VA, 6'b0}
//   era_pc              exception return address (ERA)
//   has_int             an enabled interrupt is pending and CRMD.IE is set
module csr_regfile #(
  parameter int          SAVE_NUM = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam logic [12:0]        LIE_MASK = 13'h1bff;
  localparam logic [TIMER_W-1:0] CNT_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [1:0]         crmd_plv;
  logic               crmd_ie;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         estat_is_sw;
  logic [7:0]         estat_is_hw;
  logic               estat_is_ipi;
  logic               timer_flag;
  logic [5:0]         estat_ecode;
  logic [8:0]         estat_esubcode;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry_va;
  logic [31:0]        save_q [SAVE_NUM];
  logic [31:0]        tid;
  logic               tcfg_en;
  logic               tcfg_periodic;
  logic [TIMER_W-3:0] tcfg_initval;
  logic [TIMER_W-1:0] cnt;

  logic [12:0] estat_is;
  logic [31:0] tcfg_rd;
  logic [31:0] wdata;
  logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv;
  logic        wr_eentry, wr_tid, wr_tcfg, wr_ticlr;
  logic        tcfg_load;
  logic        timer_fire;

  assign estat_is = {estat_is_ipi, timer_flag, 1'b0, estat_is_hw, estat_is_sw};
  assign tcfg_rd  = 32'({tcfg_initval, tcfg_periodic, tcfg_en});

  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {28'b0, 1'b1, crmd_ie, crmd_plv};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
      CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = tcfg_rd;
      CSR_TVAL:   csr_rvalue = 32'(cnt);
      default:    csr_rvalue = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (csr_num == CSR_SAVE0 + 14'(i)) csr_rvalue = save_q[i];
    end
  end

  // The read mux already presents the old value of the addressed register,
  // so a single merge serves every register; each one keeps only its
  // writable fields out of it.
  assign wdata = (csr_wvalue & csr_wmask) | (csr_rvalue & ~csr_wmask);

  assign wr_crmd   = csr_we && (csr_num == CSR_CRMD);
  assign wr_prmd   = csr_we && (csr_num == CSR_PRMD);
  assign wr_ecfg   = csr_we && (csr_num == CSR_ECFG);
  assign wr_estat  = csr_we && (csr_num == CSR_ESTAT);
  assign wr_era    = csr_we && (csr_num == CSR_ERA);
  assign wr_badv   = csr_we && (csr_num == CSR_BADV);
  assign wr_eentry = csr_we && (csr_num == CSR_EENTRY);
  assign wr_tid    = csr_we && (csr_num == CSR_TID);
  assign wr_tcfg   = csr_we && (csr_num == CSR_TCFG);
  assign wr_ticlr  = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

  // A TCFG write that leaves En set restarts the count and preempts the
  // ordinary decrement/expiry for that edge.
  assign tcfg_load  = wr_tcfg && wdata[0];
  assign timer_fire = tcfg_en && (cnt == '0) && !tcfg_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv <= 2'b0;
      crmd_ie  <= 1'b0;
    end else if (wb_ex) begin
      crmd_plv <= 2'b0;
      crmd_ie  <= 1'b0;
    end else if (ertn_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (wr_crmd) begin
      crmd_plv <= wdata[1:0];
      crmd_ie  <= wdata[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prmd_pplv <= 2'b0;
      prmd_pie  <= 1'b0;
    end else if (wb_ex) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
    end else if (wr_prmd) begin
      prmd_pplv <= wdata[1:0];
      prmd_pie  <= wdata[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ecfg_lie <= '0;
    else if (wr_ecfg) ecfg_lie <= wdata[12:0] & LIE_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estat_is_sw    <= '0;
      estat_is_hw    <= '0;
      estat_is_ipi   <= 1'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
    end else begin
      estat_is_hw  <= hw_int_in;
      estat_is_ipi <= ipi_int_in;
      if (wb_ex) begin
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
      end else if (wr_estat) begin
        estat_is_sw <= wdata[1:0];
      end
    end
  end

  // Setting the flag takes precedence over a simultaneous TICLR clear.
  always_ff @(posedge clk) begin
    if (reset) timer_flag <= 1'b0;
    else if (timer_fire) timer_flag <= 1'b1;
    else if (wr_ticlr) timer_flag <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) era <= '0;
    else if (wb_ex) era <= wb_pc;
    else if (wr_era) era <= wdata;
  end

  // Only fetch-side address errors (0x08/0) and memory address errors (0x09)
  // carry a bad address; other exceptions leave BADV alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      badv <= '0;
    end else if (wb_ex) begin
      if (wb_ecode == 6'h08 && wb_esubcode == 9'h0) badv <= wb_pc;
      else if (wb_ecode == 6'h09) badv <= wb_vaddr;
    end else if (wr_badv) begin
      badv <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) eentry_va <= '0;
    else if (wr_eentry) eentry_va <= wdata[31:6];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (reset) save_q[i] <= '0;
      else if (csr_we && (csr_num == CSR_SAVE0 + 14'(i))) save_q[i] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tid <= TID_INIT;
    else if (wr_tid) tid <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_en       <= 1'b0;
      tcfg_periodic <= 1'b0;
      tcfg_initval  <= '0;
    end else if (wr_tcfg) begin
      tcfg_en       <= wdata[0];
      tcfg_periodic <= wdata[1];
      tcfg_initval  <= wdata[TIMER_W-1:2];
    end
  end

  // All-ones is the idle value: a one-shot timer decrements past zero into
  // it and then stays there until reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '1;
    end else if (tcfg_load) begin
      cnt <= {wdata[TIMER_W-1:2], 2'b00};
    end else if (tcfg_en && (cnt != '1)) begin
      if ((cnt == '0) && tcfg_periodic) cnt <= {tcfg_initval, 2'b00};
      else cnt <= cnt - CNT_ONE;
    end
  end

  assign has_int  = (|(estat_is & ecfg_lie)) & crmd_ie;
  assign ex_entry = {eentry_va, 6'b0};
  assign era_pc   = era;

endmodule
